spi_slave_rx_tx: RTL and testbench
==================================

# spi_slave_rx_tx

Serial front end of the SPI-to-RAM path: deserialises MOSI frames into 10-bit command/data words for the single-port RAM (`rx_data`/`rx_valid`), and serialises the RAM's 8-bit read data (`tx_data`/`tx_valid`) back onto MISO. It sits directly upstream of the RAM and owns the SPI framing and the read-address/read-data sequencing state. All logic runs on `clk`, which is also the SPI serial clock (mode 0: MOSI sampled and MISO updated on the rising edge).

## Interface
- No parameters; frame length is fixed at 10 bits and read-data length at 8 bits.
- `clk` in 1: system/SPI clock; all sampling on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `SS_n` in 1: slave select, active-low; high aborts and frames any transaction.
- `MOSI` in 1: serial in, MSB first.
- `MISO` out 1: serial out, MSB first; 0 when not shifting read data.
- `rx_data` out 10: captured frame; [9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload. Zero-extended to 11 bits at top level.
- `rx_valid` out 1: one-cycle pulse, `rx_data` complete.
- `tx_data` in 8: RAM read data.
- `tx_valid` in 1: `tx_data` is valid.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Encoding is free; state register reset to IDLE.
- IDLE: MISO=0, bit counter=0. `SS_n`=0 → CHK_CMD.
- CHK_CMD: samples MOSI as frame bit 9 into the shift register, counter=1. MOSI=0 → WRITE; MOSI=1 and `rd_addr_done`=0 → READ_ADD; MOSI=1 and `rd_addr_done`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI into the low end of the shift register, one bit per cycle, for bits 8..0. Counter increments to 10.
- Frame completion (10th bit sampled): `rx_data` ← shift register, `rx_valid`=1 for exactly the next cycle. `rx_data` then holds until the next completed frame.
- `rd_addr_done` flag:
  - Reset to 0.
  - Set on completion of a READ_ADD frame.
  - Cleared on completion of a READ_DATA frame.
  - Unaffected by WRITE frames or aborts.
- READ_DATA after completion:
  - Waits for `tx_valid`=1.
  - Latches `tx_data` on the first such cycle.
  - Drives MISO with bits 7..0 on the 8 following cycles.
  - Then drives MISO=0 and ignores `tx_valid` until `SS_n`=1.
- WRITE/READ_ADD after completion: ignore MOSI until `SS_n`=1.
- `SS_n`=1 in any non-IDLE state:
  - Next state is IDLE.
  - Counter is cleared and MISO=0.
  - A partial frame is discarded, with no `rx_valid` and no flag change.
  - A partial MISO byte is abandoned.
- Payload bits are passed through unmodified; the slave does not check command consistency. The first bit chooses the path, and bits [9:8] go to the RAM as captured.

## Timing
- Reset values: MISO=0, `rx_data`=0, `rx_valid`=0, state=IDLE, counter=0, `rd_addr_done`=0, internal tx byte=0.
- `SS_n` falling is seen at edge 0 (IDLE→CHK_CMD). Frame bits are sampled at edges 1..10, and `rx_valid` is high during the cycle after edge 10.
- Read latency: `tx_valid` is sampled high at edge N, and MISO carries bit 7 after edge N+1 and bit 0 after edge N+8.
- `tx_valid` and `SS_n`=1 in the same cycle: abort wins and no MISO shift occurs.
- `SS_n`=1 on the edge that would sample bit 0: the frame is discarded.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous). `rd_addr_done` is cleared.
- Back-to-back frames need at least one `SS_n`-high cycle between them.

## Test plan
- Write address: `SS_n`↓, MOSI 00_1010_0101 → one `rx_valid` pulse with `rx_data`=0x0A5, state returns to IDLE after `SS_n`↑, and `rd_addr_done` stays 0.
- Write data: frame 01_0011_1100 → `rx_data`=0x13C with a single `rx_valid`. MISO stays 0 throughout.
- Read sequence:
  - Frame 10_0000_0111 → `rx_data`=0x207 and `rd_addr_done`=1.
  - Next frame 11_xxxx_xxxx → READ_DATA path and `rx_data`=0x3xx.
  - `tx_valid` with `tx_data`=0xB6 → MISO 1,0,1,1,0,1,1,0 on the following 8 cycles, and `rd_addr_done`=0.
- Abort: `SS_n`↑ after 6 bits of any frame → no `rx_valid`, `rx_data` unchanged, IDLE next cycle. A subsequent full frame is captured correctly.
- Reset mid-readout: assert `rst_n`=0 during the 4th MISO bit → MISO=0 immediately and all outputs at reset values. A following 11 frame takes the READ_ADD path, since the flag is cleared.
- Read-data without prior address: after reset, frame 11_0000_0000 → routed via READ_ADD and `rd_addr_done` set. This confirms path selection by flag, not by bit 8.

Source files
------------

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI mode-0 slave front end for the SPI-to-RAM path.
// It shifts in 10-bit command/data frames MSB first and reports each one with a
// single-cycle rx_valid pulse. It also tracks whether a read address has been
// sent, and it shifts the RAM's 8-bit read data back out on MISO.
module spi_slave_rx_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  localparam logic [3:0] FRAME_BITS = 4'd10;
  localparam logic [3:0] BYTE_BITS  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;       // frame bits sampled so far
  logic [8:0]  shift_q, shift_d;           // first nine frame bits; the tenth comes straight from MOSI
  logic [9:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_addr_done_q, rd_addr_done_d;
  logic [7:0]  tx_byte_q, tx_byte_d;       // read byte being shifted out, MSB first
  logic        tx_loaded_q, tx_loaded_d;   // read byte captured for this transaction
  logic [3:0]  tx_cnt_q, tx_cnt_d;         // read bits already driven onto MISO
  logic        miso_q, miso_d;

  // State, frame capture and readout registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_byte_q      <= '0;
      tx_loaded_q    <= 1'b0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_byte_q      <= tx_byte_d;
      tx_loaded_q    <= tx_loaded_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  // Next state, frame shifting, completion and MISO readout sequencing
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_byte_d      = tx_byte_q;
    tx_loaded_d    = tx_loaded_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = miso_q;

    if (state_q == IDLE) begin
      miso_d      = 1'b0;
      bit_cnt_d   = '0;
      tx_loaded_d = 1'b0;
      tx_cnt_d    = '0;
      if (!SS_n) begin
        state_d = CHK_CMD;
      end
    end else if (SS_n) begin
      // A deasserted select drops any partial frame or byte without side effects.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      miso_d      = 1'b0;
      tx_loaded_d = 1'b0;
      tx_cnt_d    = '0;
    end else begin
      case (state_q)
        CHK_CMD: begin
          // Frame bit 9 picks the path. A read path is chosen by the flag, not by bit 8.
          shift_d   = {8'b0, MOSI};
          bit_cnt_d = 4'd1;
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_done_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end
        default: begin
          if (bit_cnt_q != FRAME_BITS) begin
            shift_d   = {shift_q[7:0], MOSI};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == FRAME_BITS - 4'd1) begin
              rx_data_d  = {shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_addr_done_d = 1'b1;
              end
              if (state_q == READ_DATA) begin
                rd_addr_done_d = 1'b0;
              end
            end
          end else if (state_q == READ_DATA) begin
            // After the frame: capture one read byte, shift it out, then drive zeros.
            if (!tx_loaded_q) begin
              if (tx_valid) begin
                tx_byte_d   = tx_data;
                tx_loaded_d = 1'b1;
                tx_cnt_d    = '0;
              end
            end else if (tx_cnt_q != BYTE_BITS) begin
              miso_d    = tx_byte_q[7];
              tx_byte_d = {tx_byte_q[6:0], 1'b0};
              tx_cnt_d  = tx_cnt_q + 4'd1;
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Testbench for spi_slave_rx_tx. It drives directed and random SPI frames and
// read bytes. A frame-level model tracks the expected rx_data value and the
// read-address flag.
module tb_spi_slave_rx_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       model_flag;
  logic [9:0] model_rx;

  always #5 clk = ~clk;

  spi_slave_rx_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model of one completed frame. It returns 1 when the frame is a read-data
  // frame, which then returns the RAM byte on MISO.
  task automatic model_frame(input logic [9:0] f, output bit rd_path);
    rd_path  = 1'b0;
    model_rx = f;
    if (f[9]) begin
      if (model_flag) begin
        rd_path    = 1'b1;
        model_flag = 1'b0;
      end else begin
        model_flag = 1'b1;
      end
    end
  endtask

  // Lower SS_n, wait one edge, then send nbits bits of f MSB first. It records
  // rx_valid pulses, the captured word and any stray MISO activity. tx_valid
  // toggles randomly during the frame and must be ignored.
  task automatic send_bits(input logic [9:0] f, input int nbits, output int pulses,
                           output logic [9:0] cap, output int miso_ones);
    pulses    = 0;
    cap       = '0;
    miso_ones = 0;
    SS_n      = 1'b0;
    MOSI      = 1'($urandom);
    tick;
    for (int i = 0; i < nbits; i++) begin
      MOSI     = f[9-i];
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      tick;
      if (rx_valid) begin
        pulses++;
        cap = rx_data;
      end
      if (MISO) miso_ones++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic end_frame;
    SS_n     = 1'b1;
    MOSI     = 1'($urandom);
    tx_valid = 1'b0;
    tick;
  endtask

  // Present byte b after wait_cyc cycles, collect the 8 MISO bits that follow,
  // and then count any MISO activity where MISO must stay 0.
  task automatic read_out(input logic [7:0] b, input int wait_cyc,
                          output logic [7:0] got, output int stray);
    stray    = 0;
    got      = '0;
    tx_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      tx_data = 8'($urandom);
      tick;
      if (MISO) stray++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick;
    if (MISO) stray++;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 7; k >= 0; k--) begin
      tick;
      got[k] = MISO;
    end
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (MISO) stray++;
    end
    tx_valid = 1'b0;
  endtask

  // Leave the slave in READ_DATA right after a completed 11 frame, with SS_n still low.
  task automatic setup_read_frame(output logic [9:0] f);
    int         p;
    int         o;
    logic [9:0] c;
    bit         rd;
    if (!model_flag) begin
      f = {2'b10, 8'($urandom)};
      send_bits(f, 10, p, c, o);
      model_frame(f, rd);
      end_frame;
    end
    f = {2'b11, 8'($urandom)};
    send_bits(f, 10, p, c, o);
    model_frame(f, rd);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    model_flag = 1'b0;
    model_rx   = '0;
    #12;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    n_checks++; if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_rx_valid: got %b expected 0", rx_valid); end
    $display("reset: outputs checked");
  endtask

  task automatic test_write_addr;
    logic [9:0] f, cap;
    int         p, o;
    bit         rd;
    f = 10'h0A5;
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL wa_pulses: got %0d expected 1", p); end
    n_checks++; if (cap !== model_rx) begin n_fail++; $display("FAIL wa_rx_data: got %h expected %h", cap, model_rx); end
    end_frame;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL wa_pulse_width: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== model_rx) begin n_fail++; $display("FAIL wa_rx_hold: got %h expected %h", rx_data, model_rx); end
    $display("write_addr: frame %h captured %h", f, cap);
  endtask

  task automatic test_write_data;
    logic [9:0] f, cap;
    logic [7:0] got;
    int         p, o, s;
    bit         rd;
    f = 10'h13C;
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL wd_pulses: got %0d expected 1", p); end
    n_checks++; if (cap !== model_rx) begin n_fail++; $display("FAIL wd_rx_data: got %h expected %h", cap, model_rx); end
    read_out(8'hFF, 0, got, s);
    n_checks++; if ((got !== 8'h00) || (s !== 0) || (o !== 0)) begin n_fail++; $display("FAIL wd_miso_quiet: got byte %h stray %0d/%0d expected 00 0/0", got, s, o); end
    end_frame;
    $display("write_data: frame %h captured %h", f, cap);
  endtask

  task automatic test_read_seq;
    logic [9:0] f, cap;
    logic [7:0] got;
    int         p, o, s;
    bit         rd;
    f = 10'h207;
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if (cap !== model_rx) begin n_fail++; $display("FAIL rs_addr_rx: got %h expected %h", cap, model_rx); end
    read_out(8'h5A, 1, got, s);
    n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL rs_addr_miso: got %h expected 00", got); end
    end_frame;
    $display("read_addr: frame %h captured %h", f, cap);

    f = {2'b11, 8'($urandom)};
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if (cap !== model_rx) begin n_fail++; $display("FAIL rs_data_rx: got %h expected %h", cap, model_rx); end
    read_out(8'hB6, int'($urandom_range(0, 3)), got, s);
    n_checks++; if (got !== (rd ? 8'hB6 : 8'h00)) begin n_fail++; $display("FAIL rs_data_miso: got %h expected %h", got, rd ? 8'hB6 : 8'h00); end
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL rs_data_stray: got %0d stray MISO highs expected 0", s); end
    end_frame;
    $display("read_data: frame %h captured %h miso %h", f, cap, got);

    // The flag is now clear, so another 11 frame is a read-address frame again.
    f = {2'b11, 8'($urandom)};
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    read_out(8'hC3, 0, got, s);
    n_checks++; if (got !== (rd ? 8'hC3 : 8'h00)) begin n_fail++; $display("FAIL rs_flag_cleared: got %h expected %h", got, rd ? 8'hC3 : 8'h00); end
    end_frame;
    $display("read_after_read: frame %h miso %h", f, got);
  endtask

  task automatic test_abort;
    logic [9:0] f, cap;
    logic [7:0] got, b;
    int         p, o, s;
    bit         rd;
    f = 10'($urandom);
    send_bits(f, 6, p, cap, o);
    end_frame;
    n_checks++; if ((p !== 0) || (rx_valid !== 1'b0)) begin n_fail++; $display("FAIL ab6_pulse: got %0d/%b expected 0/0", p, rx_valid); end
    n_checks++; if (rx_data !== model_rx) begin n_fail++; $display("FAIL ab6_rx_hold: got %h expected %h", rx_data, model_rx); end
    $display("abort_6: frame %h dropped", f);

    // Abort on the same edge that would sample bit 0.
    f = 10'($urandom);
    send_bits(f, 9, p, cap, o);
    MOSI = f[0];
    SS_n = 1'b1;
    tick;
    n_checks++; if ((p !== 0) || (rx_valid !== 1'b0)) begin n_fail++; $display("FAIL ab9_pulse: got %0d/%b expected 0/0", p, rx_valid); end
    n_checks++; if (rx_data !== model_rx) begin n_fail++; $display("FAIL ab9_rx_hold: got %h expected %h", rx_data, model_rx); end
    $display("abort_9: frame %h dropped", f);

    f = 10'($urandom);
    b = 8'($urandom);
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if ((p !== 1) || (cap !== model_rx)) begin n_fail++; $display("FAIL ab_recover: got %0d pulses rx %h expected 1 pulse rx %h", p, cap, model_rx); end
    read_out(b, 0, got, s);
    n_checks++; if (got !== (rd ? b : 8'h00)) begin n_fail++; $display("FAIL ab_recover_miso: got %h expected %h", got, rd ? b : 8'h00); end
    end_frame;
    $display("abort_recover: frame %h captured %h", f, cap);
  endtask

  task automatic test_abort_readout;
    logic [9:0] f;
    logic [7:0] b;
    int         s;
    // Abort partway through the byte.
    setup_read_frame(f);
    b = 8'($urandom);
    tx_data  = b;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    repeat (3) tick;
    n_checks++; if (MISO !== b[5]) begin n_fail++; $display("FAIL abr_third_bit: got %b expected %b", MISO, b[5]); end
    SS_n     = 1'b1;
    tx_valid = 1'b1;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (MISO) s++;
    end
    tx_valid = 1'b0;
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL abr_miso_zero: got %0d MISO highs expected 0", s); end
    $display("abort_readout: frame %h byte %h", f, b);

    // tx_valid and SS_n high on the same edge: the abort wins.
    setup_read_frame(f);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    SS_n     = 1'b1;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (MISO) s++;
    end
    tx_valid = 1'b0;
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL abr_same_cycle: got %0d MISO highs expected 0", s); end
    $display("abort_same_cycle: frame %h", f);
  endtask

  task automatic test_reset_midreadout;
    logic [9:0] f, cap;
    logic [7:0] b, got;
    int         p, o, s;
    bit         rd;
    setup_read_frame(f);
    b = 8'($urandom);
    tx_data  = b;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    repeat (4) tick;
    n_checks++; if (MISO !== b[4]) begin n_fail++; $display("FAIL rm_fourth_bit: got %b expected %b", MISO, b[4]); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rm_miso: got %b expected 0", MISO); end
    n_checks++; if ((rx_data !== 10'h000) || (rx_valid !== 1'b0)) begin n_fail++; $display("FAIL rm_outputs: got %h/%b expected 000/0", rx_data, rx_valid); end
    SS_n = 1'b1;
    #1 rst_n = 1'b1;
    model_flag = 1'b0;
    model_rx   = '0;
    tick;
    $display("reset_midreadout: byte %h interrupted", b);

    // After reset, an 11 frame goes by READ_ADD. The next 11 frame gives read data.
    f = 10'h300;
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    n_checks++; if (cap !== model_rx) begin n_fail++; $display("FAIL rm_rx: got %h expected %h", cap, model_rx); end
    read_out(8'hA5, 0, got, s);
    n_checks++; if (got !== (rd ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL rm_path_readadd: got %h expected %h", got, rd ? 8'hA5 : 8'h00); end
    end_frame;
    f = {2'b11, 8'($urandom)};
    send_bits(f, 10, p, cap, o);
    model_frame(f, rd);
    read_out(8'h3C, 2, got, s);
    n_checks++; if (got !== (rd ? 8'h3C : 8'h00)) begin n_fail++; $display("FAIL rm_path_readdata: got %h expected %h", got, rd ? 8'h3C : 8'h00); end
    end_frame;
    $display("post_reset_reads: last frame %h miso %h", f, got);
  endtask

  task automatic test_random;
    logic [9:0] f, cap;
    logic [7:0] b, got;
    int         p, o, s, nb;
    bit         rd;
    for (int t = 0; t < 30; t++) begin
      f  = 10'($urandom);
      b  = 8'($urandom);
      nb = int'($urandom_range(0, 14));
      if (nb >= 10) begin
        send_bits(f, 10, p, cap, o);
        model_frame(f, rd);
        n_checks++; if ((p !== 1) || (cap !== model_rx)) begin n_fail++; $display("FAIL rnd_frame: got %0d pulses rx %h expected 1 pulse rx %h", p, cap, model_rx); end
        read_out(b, int'($urandom_range(0, 3)), got, s);
        n_checks++; if (got !== (rd ? b : 8'h00)) begin n_fail++; $display("FAIL rnd_miso: got %h expected %h", got, rd ? b : 8'h00); end
        n_checks++; if ((s !== 0) || (o !== 0)) begin n_fail++; $display("FAIL rnd_stray: got %0d/%0d MISO highs expected 0/0", s, o); end
        end_frame;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_pulse_width: got %b expected 0", rx_valid); end
        $display("random %0d: frame %h captured %h miso %h", t, f, cap, got);
      end else begin
        send_bits(f, nb, p, cap, o);
        end_frame;
        n_checks++; if ((p !== 0) || (rx_valid !== 1'b0) || (rx_data !== model_rx)) begin n_fail++; $display("FAIL rnd_abort: got %0d pulses rx %h expected 0 pulses rx %h", p, rx_data, model_rx); end
        $display("random %0d: frame %h aborted after %0d bits", t, f, nb);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_addr;
    test_write_data;
    test_read_seq;
    test_abort;
    test_abort_readout;
    test_reset_midreadout;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
